// File: rtl/fphub_mult_pkg.sv
// Shared types and constants for the HUB floating-point multiplier front end.
package fphub_mult_pkg;

  localparam int unsigned CODE_W = $clog2(7);
  localparam int unsigned PAT_W  = 64;

  typedef logic [CODE_W-1:0] spec_code_t;

  localparam spec_code_t CODE_NONE   = CODE_W'(0);
  localparam spec_code_t CODE_INF_P  = CODE_W'(1);
  localparam spec_code_t CODE_INF_N  = CODE_W'(2);
  localparam spec_code_t CODE_ZERO_P = CODE_W'(3);
  localparam spec_code_t CODE_ZERO_N = CODE_W'(4);
  localparam spec_code_t CODE_ONE_P  = CODE_W'(5);
  localparam spec_code_t CODE_ONE_N  = CODE_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLASS = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Magnitude patterns (sign excluded) for exponent width e and mantissa width m.
  function automatic logic [PAT_W-1:0] pos_inf(input int unsigned e, input int unsigned m);
    return (PAT_W'(1) << (e + m)) - PAT_W'(1);
  endfunction

  function automatic logic [PAT_W-1:0] pos_zero(input int unsigned e, input int unsigned m);
    return PAT_W'(0) & pos_inf(e, m);
  endfunction

  function automatic logic [PAT_W-1:0] pos_one(input int unsigned e, input int unsigned m);
    return PAT_W'(1) << (e + m - 1);
  endfunction

  function automatic logic is_inf(input spec_code_t c);
    return (c == CODE_INF_P) || (c == CODE_INF_N);
  endfunction

  function automatic logic is_zero(input spec_code_t c);
    return (c == CODE_ZERO_P) || (c == CODE_ZERO_N);
  endfunction

  function automatic logic is_one(input spec_code_t c);
    return (c == CODE_ONE_P) || (c == CODE_ONE_N);
  endfunction

endpackage

// File: rtl/fphub_special_classifier.sv
// Combinational operand classifier: maps one HUB operand to its special-case code.
module fphub_special_classifier
  import fphub_mult_pkg::*;
#(
  parameter int unsigned M = 23,
  parameter int unsigned E = 8
) (
  input  logic [E+M:0] op,
  output spec_code_t   code_c
);

  localparam int unsigned MW = E + M;
  localparam logic [MW-1:0] MAG_INF  = MW'(pos_inf(E, M));
  localparam logic [MW-1:0] MAG_ZERO = MW'(pos_zero(E, M));
  localparam logic [MW-1:0] MAG_ONE  = MW'(pos_one(E, M));

  logic [MW-1:0] mag;
  logic          sign;

  assign mag  = op[MW-1:0];
  assign sign = op[MW];

  always_comb begin
    code_c = CODE_NONE;
    if (mag == MAG_INF) begin
      code_c = sign ? CODE_INF_N : CODE_INF_P;
    end else if (mag == MAG_ZERO) begin
      code_c = sign ? CODE_ZERO_N : CODE_ZERO_P;
    end else if (mag == MAG_ONE) begin
      code_c = sign ? CODE_ONE_N : CODE_ONE_P;
    end
  end

endmodule

// File: rtl/fphub_mult_sequencer.sv
// Front-end sequencer for the HUB multiplier: resolves special operands locally,
// dispatches normal pairs to the core and returns one result per accepted pair.
module fphub_mult_sequencer
  import fphub_mult_pkg::*;
#(
  parameter int unsigned M       = 23,
  parameter int unsigned E       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [E+M:0]   in_x,
  input  logic [E+M:0]   in_y,
  output logic           core_start,
  output logic [E+M:0]   core_x,
  output logic [E+M:0]   core_y,
  input  logic           core_done,
  input  logic [E+M:0]   core_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [E+M:0]   out_result,
  output logic           out_special,
  output logic           out_err
);

  localparam int unsigned W  = E + M + 1;
  localparam int unsigned MW = E + M;
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [MW-1:0] MAG_INF  = MW'(pos_inf(E, M));
  localparam logic [MW-1:0] MAG_ZERO = MW'(pos_zero(E, M));
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  spec_code_t      in_code_x_c, in_code_y_c;
  spec_code_t      code_x_q, code_x_d, code_y_q, code_y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_d, core_start_d, out_valid_d, out_special_d, out_err_d;
  logic [W-1:0]    core_x_d, core_y_d, out_result_d;
  logic [MW-1:0]   spec_mag_c;
  logic            spec_sign_c;
  logic            is_special_c;

  // Operands are classified as they arrive so the dispatch decision is known in CLASS.
  fphub_special_classifier #(.M(M), .E(E)) u_class_x (.op(in_x), .code_c(in_code_x_c));
  fphub_special_classifier #(.M(M), .E(E)) u_class_y (.op(in_y), .code_c(in_code_y_c));

  // Special-result magnitude: INF beats ZERO (INF*0 -> INF), then the ONE shortcuts.
  always_comb begin
    spec_mag_c = core_x[MW-1:0];
    if (is_inf(code_x_q) || is_inf(code_y_q)) begin
      spec_mag_c = MAG_INF;
    end else if (is_zero(code_x_q) || is_zero(code_y_q)) begin
      spec_mag_c = MAG_ZERO;
    end else if (is_one(code_x_q)) begin
      spec_mag_c = core_y[MW-1:0];
    end
  end

  assign spec_sign_c  = core_x[MW] ^ core_y[MW];
  assign is_special_c = (code_x_q != CODE_NONE) || (code_y_q != CODE_NONE);

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready;
    core_start_d  = 1'b0;
    core_x_d      = core_x;
    core_y_d      = core_y;
    code_x_d      = code_x_q;
    code_y_d      = code_y_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid;
    out_result_d  = out_result;
    out_special_d = out_special;
    out_err_d     = out_err;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          core_x_d     = in_x;
          core_y_d     = in_y;
          code_x_d     = in_code_x_c;
          code_y_d     = in_code_y_c;
          in_ready_d   = 1'b0;
          core_start_d = (in_code_x_c == CODE_NONE) && (in_code_y_c == CODE_NONE);
          state_d      = ST_CLASS;
        end
      end
      ST_CLASS: begin
        if (is_special_c) begin
          out_result_d  = {spec_sign_c, spec_mag_c};
          out_special_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = ST_OUT;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done) begin
          out_result_d  = core_result;
          out_special_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_OUT;
        end else if (cnt_q == CNT_LAST) begin
          out_result_d = {spec_sign_c, MAG_INF};
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = ST_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d   = 1'b0;
          out_special_d = 1'b0;
          out_err_d     = 1'b0;
          in_ready_d    = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      core_x      <= '0;
      core_y      <= '0;
      code_x_q    <= CODE_NONE;
      code_y_q    <= CODE_NONE;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_special <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready    <= in_ready_d;
      core_start  <= core_start_d;
      core_x      <= core_x_d;
      core_y      <= core_y_d;
      code_x_q    <= code_x_d;
      code_y_q    <= code_y_d;
      cnt_q       <= cnt_d;
      out_valid   <= out_valid_d;
      out_result  <= out_result_d;
      out_special <= out_special_d;
      out_err     <= out_err_d;
    end
  end

endmodule
